// File: rtl/axi_reset_sequencer.sv
// Core-reset sequencer for the snitch cluster: gates and drains the wide AXI port
// before asserting core reset, and releases it after a fixed delay on request.
module axi_reset_sequencer #(
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned AssertCycles   = 2,
    parameter int unsigned DeassertCycles = 2,
    parameter int unsigned DrainTimeout   = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic assert_req_i,
    input  logic deassert_req_i,
    input  logic aw_fire_i,
    input  logic ar_fire_i,
    input  logic b_fire_i,
    input  logic r_last_fire_i,
    output logic core_rst_no,
    output logic gate_o,
    output logic assert_ack_o,
    output logic deassert_ack_o,
    output logic timeout_o,
    output logic count_err_o,
    output logic busy_o
);

    localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);
    localparam int unsigned DrnW   = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam int unsigned DlyMax = (AssertCycles > DeassertCycles) ? AssertCycles : DeassertCycles;
    localparam int unsigned DlyW   = (DlyMax > 1) ? $clog2(DlyMax + 1) : 1;

    localparam logic [CntW-1:0] CntMax     = CntW'(MaxOutstanding);
    localparam logic [DrnW-1:0] DrainLast  = DrnW'(DrainTimeout - 1);
    localparam logic [DlyW-1:0] AssertLast = DlyW'(AssertCycles - 1);
    // The HELD cycle that accepts the request counts as the first deassert cycle.
    localparam logic [DlyW-1:0] DeassertLast = DlyW'((DeassertCycles > 1) ? DeassertCycles - 2 : 0);

    typedef enum logic [2:0] {
        ST_RUN, ST_DRAIN, ST_ASSERT, ST_HELD, ST_DEASSERT
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [DrnW-1:0] drn_cnt_q, drn_cnt_d;
    logic [DlyW-1:0] dly_cnt_q, dly_cnt_d;
    logic            pend_q, pend_d;
    logic            core_rst_q, core_rst_d;
    logic            gate_q, gate_d;
    logic            aack_q, aack_d;
    logic            dack_q, dack_d;
    logic            tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_HELD;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            drn_cnt_q  <= '0;
            dly_cnt_q  <= '0;
            pend_q     <= 1'b0;
            core_rst_q <= 1'b0;
            gate_q     <= 1'b1;
            aack_q     <= 1'b0;
            dack_q     <= 1'b0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            drn_cnt_q  <= drn_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            pend_q     <= pend_d;
            core_rst_q <= core_rst_d;
            gate_q     <= gate_d;
            aack_q     <= aack_d;
            dack_q     <= dack_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        drn_cnt_d = '0;
        dly_cnt_d = '0;
        pend_d    = pend_q;
        aack_d    = 1'b0;
        dack_d    = 1'b0;
        tmo_d     = tmo_q;
        err_d     = err_q;

        // Outstanding tracking only while the port can still carry traffic.
        if (state_q == ST_RUN || state_q == ST_DRAIN) begin
            if (aw_fire_i && !b_fire_i) begin
                if (wr_cnt_q == CntMax) err_d = 1'b1;
                else                    wr_cnt_d = wr_cnt_q + 1'b1;
            end else if (b_fire_i && !aw_fire_i) begin
                if (wr_cnt_q == '0) err_d = 1'b1;
                else                wr_cnt_d = wr_cnt_q - 1'b1;
            end
            if (ar_fire_i && !r_last_fire_i) begin
                if (rd_cnt_q == CntMax) err_d = 1'b1;
                else                    rd_cnt_d = rd_cnt_q + 1'b1;
            end else if (r_last_fire_i && !ar_fire_i) begin
                if (rd_cnt_q == '0) err_d = 1'b1;
                else                rd_cnt_d = rd_cnt_q - 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (assert_req_i) begin
                    state_d = ST_DRAIN;
                    pend_d  = deassert_req_i;
                end else if (deassert_req_i) begin
                    dack_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                drn_cnt_d = drn_cnt_q + 1'b1;
                if (deassert_req_i) pend_d = 1'b1;
                if (wr_cnt_q == '0 && rd_cnt_q == '0) begin
                    state_d = ST_ASSERT;
                end else if (drn_cnt_q == DrainLast) begin
                    state_d = ST_ASSERT;
                    tmo_d   = 1'b1;
                end
            end
            ST_ASSERT: begin
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                if (deassert_req_i) pend_d = 1'b1;
                if (dly_cnt_q == AssertLast) begin
                    state_d = ST_HELD;
                    aack_d  = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (deassert_req_i || pend_q) begin
                    state_d = ST_DEASSERT;
                    pend_d  = 1'b0;
                end else if (assert_req_i) begin
                    aack_d = 1'b1;
                end
            end
            ST_DEASSERT: begin
                if (dly_cnt_q == DeassertLast) begin
                    state_d = ST_RUN;
                    dack_d  = 1'b1;
                    tmo_d   = 1'b0;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_HELD;
        endcase

        // Level outputs follow the state being entered so they stay registered.
        core_rst_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        gate_d     = (state_d != ST_RUN);
        busy_d     = (state_d == ST_DRAIN) || (state_d == ST_ASSERT) || (state_d == ST_DEASSERT);
    end

    assign core_rst_no    = core_rst_q;
    assign gate_o         = gate_q;
    assign assert_ack_o   = aack_q;
    assign deassert_ack_o = dack_q;
    assign timeout_o      = tmo_q;
    assign count_err_o    = err_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_axi_reset_sequencer.sv
// Bench for axi_reset_sequencer: directed test-plan scenarios then random traffic,
// two instances (default and short drain timeout) checked against a deadline-based model.
module tb_axi_reset_sequencer;

    localparam int MAXO = 16;
    localparam int AC   = 2;
    localparam int DC   = 2;
    localparam int DT0  = 1024;
    localparam int DT1  = 8;

    localparam int P_RUN = 0, P_DRAIN = 1, P_ASSERT = 2, P_HELD = 3, P_DEASSERT = 4;

    localparam logic [5:0] A  = 6'b100000;
    localparam logic [5:0] D  = 6'b010000;
    localparam logic [5:0] AW = 6'b001000;
    localparam logic [5:0] AR = 6'b000100;
    localparam logic [5:0] B  = 6'b000010;
    localparam logic [5:0] RL = 6'b000001;
    localparam logic [5:0] NO = 6'b000000;
    localparam logic [6:0] RST_OUTS = 7'b0100000;

    logic clk, rst_n;
    logic assert_req, deassert_req, aw_fire, ar_fire, b_fire, r_last_fire;
    logic rst0, gate0, aack0, dack0, tmo0, err0, busy0;
    logic rst1, gate1, aack1, dack1, tmo1, err1, busy1;

    int nchk, nerr, n;
    int ph[2], wr[2], rd[2], dl[2];
    bit pend[2], tmo[2], err[2], aack[2], dack[2];

    axi_reset_sequencer #(.MaxOutstanding(MAXO), .AssertCycles(AC), .DeassertCycles(DC), .DrainTimeout(DT0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .assert_req_i(assert_req), .deassert_req_i(deassert_req),
        .aw_fire_i(aw_fire), .ar_fire_i(ar_fire), .b_fire_i(b_fire), .r_last_fire_i(r_last_fire),
        .core_rst_no(rst0), .gate_o(gate0), .assert_ack_o(aack0), .deassert_ack_o(dack0),
        .timeout_o(tmo0), .count_err_o(err0), .busy_o(busy0));

    axi_reset_sequencer #(.MaxOutstanding(MAXO), .AssertCycles(AC), .DeassertCycles(DC), .DrainTimeout(DT1)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .assert_req_i(assert_req), .deassert_req_i(deassert_req),
        .aw_fire_i(aw_fire), .ar_fire_i(ar_fire), .b_fire_i(b_fire), .r_last_fire_i(r_last_fire),
        .core_rst_no(rst1), .gate_o(gate1), .assert_ack_o(aack1), .deassert_ack_o(dack1),
        .timeout_o(tmo1), .count_err_o(err1), .busy_o(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [6:0] mexp(input int k);
        mexp = {ph[k] == P_RUN || ph[k] == P_DRAIN, ph[k] != P_RUN, aack[k], dack[k], tmo[k], err[k],
                ph[k] == P_DRAIN || ph[k] == P_ASSERT || ph[k] == P_DEASSERT};
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = P_HELD; wr[k] = 0; rd[k] = 0; dl[k] = 0;
            pend[k] = 0; tmo[k] = 0; err[k] = 0; aack[k] = 0; dack[k] = 0;
        end
    endtask

    // Tracks phase deadlines as absolute cycle numbers rather than counters.
    task automatic mstep(input int k, input int dt, input logic [5:0] v);
        bit a, d, empty;
        int nph;
        a = v[5]; d = v[4];
        nph = ph[k]; aack[k] = 0; dack[k] = 0;
        empty = (wr[k] == 0) && (rd[k] == 0);
        if (ph[k] == P_RUN || ph[k] == P_DRAIN) begin
            if (v[3] != v[1]) begin
                if (v[3]) begin if (wr[k] == MAXO) err[k] = 1; else wr[k]++; end
                else      begin if (wr[k] == 0)    err[k] = 1; else wr[k]--; end
            end
            if (v[2] != v[0]) begin
                if (v[2]) begin if (rd[k] == MAXO) err[k] = 1; else rd[k]++; end
                else      begin if (rd[k] == 0)    err[k] = 1; else rd[k]--; end
            end
        end
        case (ph[k])
            P_RUN: begin
                if (a) begin nph = P_DRAIN; dl[k] = n + dt; pend[k] = d; end
                else if (d) dack[k] = 1;
            end
            P_DRAIN: begin
                if (d) pend[k] = 1;
                if (empty) begin nph = P_ASSERT; dl[k] = n + AC; end
                else if (n == dl[k]) begin nph = P_ASSERT; dl[k] = n + AC; tmo[k] = 1; end
            end
            P_ASSERT: begin
                wr[k] = 0; rd[k] = 0;
                if (d) pend[k] = 1;
                if (n == dl[k]) begin nph = P_HELD; aack[k] = 1; end
            end
            P_HELD: begin
                if (d || pend[k]) begin nph = P_DEASSERT; pend[k] = 0; dl[k] = n + DC - 1; end
                else if (a) aack[k] = 1;
            end
            default: begin
                if (n == dl[k]) begin nph = P_RUN; dack[k] = 1; tmo[k] = 0; end
            end
        endcase
        ph[k] = nph;
    endtask

    task automatic tick(input logic [5:0] v);
        {assert_req, deassert_req, aw_fire, ar_fire, b_fire, r_last_fire} = v;
        mstep(0, DT0, v);
        mstep(1, DT1, v);
        @(posedge clk); #1;
        n++;
        chk("outs_dut", {rst0, gate0, aack0, dack0, tmo0, err0, busy0}, mexp(0));
        chk("outs_dut_to", {rst1, gate1, aack1, dack1, tmo1, err1, busy1}, mexp(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {assert_req, deassert_req, aw_fire, ar_fire, b_fire, r_last_fire} = '0;
        #1;
        chk("rst_state_dut", {rst0, gate0, aack0, dack0, tmo0, err0, busy0}, RST_OUTS);
        chk("rst_state_dut_to", {rst1, gate1, aack1, dack1, tmo1, err1, busy1}, RST_OUTS);
        mreset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pwr_up();
        tick(NO); tick(NO); tick(D);
        chk("pwr_rst_low", rst0, 0);
        tick(NO);
        chk("pwr_rst_high", rst0, 1);
        chk("pwr_dack", dack0, 1);
    endtask

    initial begin
        nchk = 0; nerr = 0; n = 0;
        rst_n = 1'b0;
        {assert_req, deassert_req, aw_fire, ar_fire, b_fire, r_last_fire} = '0;
        mreset();
        @(posedge clk); #1;
        do_reset();
        pwr_up();

        // clean assert with nothing outstanding
        tick(A);
        chk("ca_gate", gate0, 1); chk("ca_rst_t1", rst0, 1);
        tick(NO); chk("ca_rst_t2", rst0, 0);
        tick(NO); chk("ca_ack_t3", aack0, 0);
        tick(NO); chk("ca_ack_t4", aack0, 1);
        tick(NO); chk("ca_ack_t5", aack0, 0);
        tick(D); tick(NO); chk("ca_release", rst0, 1);

        // drain with late final write response
        repeat (3) tick(AW);
        repeat (2) tick(AR);
        tick(A);
        begin
            logic [5:0] pat [10];
            pat = '{B, NO, RL, NO, B, NO, RL, NO, NO, NO};
            for (int i = 0; i < 10; i++) begin tick(pat[i]); chk("drn_hold", rst0, 1); end
        end
        repeat (19) begin tick(NO); chk("drn_hold", rst0, 1); end
        tick(B);  chk("drn_after_b", rst0, 1);
        tick(NO); chk("drn_asserted", rst0, 0); chk("drn_no_tmo", tmo0, 0);
        tick(NO); tick(NO); chk("drn_ack", aack0, 1);
        tick(D); tick(NO); chk("drn_release", rst0, 1);

        // timeout on the short-timeout instance; the default one stays in DRAIN
        tick(AW); tick(A);
        repeat (7) begin tick(NO); chk("to_draining", rst1, 1); end
        tick(NO); chk("to_asserted", rst1, 0); chk("to_flag", tmo1, 1);
        tick(NO); tick(NO); chk("to_ack", aack1, 1);
        tick(D); tick(NO);
        chk("to_dack", dack1, 1); chk("to_cleared", tmo1, 0); chk("to_other_drain", busy0, 1);

        // async reset while the default instance is draining
        do_reset();
        tick(NO); chk("ar_no_ack", aack0, 0); chk("ar_held", rst0, 0);
        pwr_up();

        // collision: both requests in one RUN cycle
        tick(A | D);
        tick(NO); tick(NO); tick(NO); chk("col_aack", aack0, 1);
        tick(NO); chk("col_deassert_busy", busy0, 1); chk("col_rst_low", rst0, 0);
        tick(NO); chk("col_dack", dack0, 1); chk("col_rst_high", rst0, 1);

        // write counter saturation
        repeat (17) tick(AW);
        chk("sat_cnt", dut.wr_cnt_q, MAXO); chk("sat_err", err0, 1);
        do_reset();
        pwr_up();
        chk("err_cleared", err0, 0);

        // write counter underflow
        tick(B);
        chk("unf_err", err0, 1); chk("unf_cnt", dut.wr_cnt_q, 0);
        do_reset();
        pwr_up();

        // random traffic and requests
        repeat (3000) begin
            logic [5:0] v;
            v[5] = ($urandom_range(0, 19) == 0);
            v[4] = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
